// File: rtl/axis_image_receiver.sv
// ---------------------------------------------------------------------------
// axis_image_receiver
//
// AXI-Stream image sink. Accepts one pixel per beat (tuser = start of frame,
// tlast = end of line), tracks row/column, checks framing and writes each
// accepted pixel to a linear frame-buffer write port. Completed frames are
// counted; beats seen while waiting for a start of frame are discarded and
// counted.
//
// Optional feature (macro AXIS_RX_THROTTLE_EN):
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1)
//   forces s_axis_tready low whenever lfsr[1:0] == 2'b00, giving roughly 25%
//   pseudo-random backpressure. When undefined, tready depends on state only.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   enable            arms reception; looked at only in IDLE and DONE
//   cfg_cols/rows     frame geometry, sampled on the SOF beat (0 means 1)
//   s_axis_*          AXI-Stream slave (tvalid/tready/tdata/tlast/tuser)
//   wr_en/addr/data   registered frame-buffer write port (addr = row*cols+col)
//   frame_done        one-cycle pulse while the FSM sits in DONE
//   frame_count       completed frames, wraps
//   drop_count        beats discarded before SOF, saturates
//   err_*             sticky framing error flags, cleared by err_clear
// ---------------------------------------------------------------------------
module axis_image_receiver #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int ADDR_W               = 16,
  parameter int DIM_W                = 12
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [DIM_W-1:0]                cfg_cols,
  input  logic [DIM_W-1:0]                cfg_rows,
  input  logic                            s_axis_tvalid,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tuser,
  output logic                            s_axis_tready,
  output logic                            wr_en,
  output logic [ADDR_W-1:0]               wr_addr,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] wr_data,
  output logic                            frame_done,
  output logic [15:0]                     frame_count,
  output logic [15:0]                     drop_count,
  output logic                            err_sof_unexp,
  output logic                            err_eol_early,
  output logic                            err_eol_missing,
  input  logic                            err_clear
);

  localparam logic [DIM_W-1:0]  DIM_ZERO  = {DIM_W{1'b0}};
  localparam logic [DIM_W-1:0]  DIM_ONE   = {{(DIM_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_RECV     = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t                            state_r;
  logic                              ready_r;
  logic [DIM_W-1:0]                  cols_r;
  logic [DIM_W-1:0]                  rows_r;
  logic [DIM_W-1:0]                  col_r;
  logic [DIM_W-1:0]                  row_r;
  logic [ADDR_W-1:0]                 addr_r;       // address of the next pixel
  logic [ADDR_W-1:0]                 line_base_r;  // address of column 0 of the current row
  logic                              wr_en_r;
  logic [ADDR_W-1:0]                 wr_addr_r;
  logic [C_S_AXIS_TDATA_WIDTH-1:0]   wr_data_r;
  logic                              frame_done_r;
  logic [15:0]                       frame_count_r;
  logic [15:0]                       drop_count_r;
  logic                              err_sof_unexp_r;
  logic                              err_eol_early_r;
  logic                              err_eol_missing_r;

  logic                              xfer_s;
  logic                              in_frame_s;
  logic                              sof_beat_s;
  logic                              accept_s;
  logic [DIM_W-1:0]                  cols_s;
  logic [DIM_W-1:0]                  rows_s;
  logic [DIM_W-1:0]                  pos_col_s;
  logic [DIM_W-1:0]                  pos_row_s;
  logic [ADDR_W-1:0]                 pos_addr_s;
  logic [ADDR_W-1:0]                 pos_base_s;
  logic                              last_col_s;
  logic                              last_row_s;
  logic                              eol_s;
  logic                              frame_end_s;
  logic [DIM_W-1:0]                  next_col_s;
  logic [DIM_W-1:0]                  next_row_s;
  logic [ADDR_W-1:0]                 next_addr_s;
  logic [ADDR_W-1:0]                 next_base_s;
  logic                              new_sof_unexp_s;
  logic                              new_eol_early_s;
  logic                              new_eol_missing_s;

`ifdef AXIS_RX_THROTTLE_EN
  logic [15:0] lfsr_r;
  logic        lfsr_fb_s;

  assign lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];

  // Free-running backpressure LFSR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_fb_s};
    end
  end

  // Both terms are registers, so tready stays glitch-free.
  assign s_axis_tready = ready_r & (lfsr_r[1:0] != 2'b00);
`else
  assign s_axis_tready = ready_r;
`endif

  assign xfer_s     = s_axis_tvalid & s_axis_tready;
  assign in_frame_s = (state_r == ST_RECV);
  // tuser only starts a frame in the two receiving states; in RECV it aborts
  // the running frame and restarts at pixel 0.
  assign sof_beat_s = s_axis_tuser & ((state_r == ST_WAIT_SOF) | in_frame_s);
  assign accept_s   = xfer_s & (sof_beat_s | in_frame_s);

  // Position of the current beat and where the following beat will land.
  always_comb begin
    cols_s     = cols_r;
    rows_s     = rows_r;
    pos_col_s  = col_r;
    pos_row_s  = row_r;
    pos_addr_s = addr_r;
    pos_base_s = line_base_r;
    if (sof_beat_s) begin
      cols_s     = (cfg_cols == DIM_ZERO) ? DIM_ONE : cfg_cols;
      rows_s     = (cfg_rows == DIM_ZERO) ? DIM_ONE : cfg_rows;
      pos_col_s  = DIM_ZERO;
      pos_row_s  = DIM_ZERO;
      pos_addr_s = ADDR_ZERO;
      pos_base_s = ADDR_ZERO;
    end else begin
      cols_s     = cols_r;
      rows_s     = rows_r;
    end

    last_col_s  = (pos_col_s == (cols_s - DIM_ONE));
    last_row_s  = (pos_row_s == (rows_s - DIM_ONE));
    // An early tlast and a missing tlast both still close the line.
    eol_s       = last_col_s | s_axis_tlast;
    frame_end_s = eol_s & last_row_s;

    // Incremental addressing: a new line starts at the old line base plus cols.
    if (eol_s) begin
      next_col_s  = DIM_ZERO;
      next_row_s  = pos_row_s + DIM_ONE;
      next_base_s = pos_base_s + ADDR_W'(cols_s);
      next_addr_s = pos_base_s + ADDR_W'(cols_s);
    end else begin
      next_col_s  = pos_col_s + DIM_ONE;
      next_row_s  = pos_row_s;
      next_base_s = pos_base_s;
      next_addr_s = pos_addr_s + ADDR_ONE;
    end

    new_sof_unexp_s   = xfer_s & in_frame_s & s_axis_tuser;
    new_eol_early_s   = accept_s & s_axis_tlast & ~last_col_s;
    new_eol_missing_s = accept_s & last_col_s & ~s_axis_tlast;
  end

  // Receive FSM with its counters and registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      ready_r       <= 1'b0;
      cols_r        <= DIM_ONE;
      rows_r        <= DIM_ONE;
      col_r         <= DIM_ZERO;
      row_r         <= DIM_ZERO;
      addr_r        <= ADDR_ZERO;
      line_base_r   <= ADDR_ZERO;
      wr_en_r       <= 1'b0;
      wr_addr_r     <= ADDR_ZERO;
      wr_data_r     <= {C_S_AXIS_TDATA_WIDTH{1'b0}};
      frame_done_r  <= 1'b0;
      frame_count_r <= 16'd0;
      drop_count_r  <= 16'd0;
    end else begin
      wr_en_r      <= 1'b0;
      frame_done_r <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            state_r <= ST_WAIT_SOF;
            ready_r <= 1'b1;
          end else begin
            ready_r <= 1'b0;
          end
        end
        ST_WAIT_SOF: begin
          if (xfer_s && !s_axis_tuser) begin
            if (drop_count_r != 16'hFFFF) begin
              drop_count_r <= drop_count_r + 16'd1;
            end else begin
              drop_count_r <= drop_count_r;
            end
          end else begin
            drop_count_r <= drop_count_r;
          end
        end
        ST_RECV: begin
          // Accepted beats are handled below, shared with the SOF beat.
          ready_r <= 1'b1;
        end
        ST_DONE: begin
          if (enable) begin
            state_r <= ST_WAIT_SOF;
            ready_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b0;
        end
      endcase

      // Every accepted pixel (SOF or mid-frame) is written and advances position.
      if (accept_s) begin
        wr_en_r     <= 1'b1;
        wr_addr_r   <= pos_addr_s;
        wr_data_r   <= s_axis_tdata;
        cols_r      <= cols_s;
        rows_r      <= rows_s;
        col_r       <= next_col_s;
        row_r       <= next_row_s;
        addr_r      <= next_addr_s;
        line_base_r <= next_base_s;
        if (frame_end_s) begin
          state_r       <= ST_DONE;
          ready_r       <= 1'b0;
          frame_done_r  <= 1'b1;
          frame_count_r <= frame_count_r + 16'd1;
        end else begin
          state_r <= ST_RECV;
          ready_r <= 1'b1;
        end
      end
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sof_unexp_r   <= 1'b0;
      err_eol_early_r   <= 1'b0;
      err_eol_missing_r <= 1'b0;
    end else begin
      err_sof_unexp_r   <= (err_sof_unexp_r & ~err_clear) | new_sof_unexp_s;
      err_eol_early_r   <= (err_eol_early_r & ~err_clear) | new_eol_early_s;
      err_eol_missing_r <= (err_eol_missing_r & ~err_clear) | new_eol_missing_s;
    end
  end

  assign wr_en           = wr_en_r;
  assign wr_addr         = wr_addr_r;
  assign wr_data         = wr_data_r;
  assign frame_done      = frame_done_r;
  assign frame_count     = frame_count_r;
  assign drop_count      = drop_count_r;
  assign err_sof_unexp   = err_sof_unexp_r;
  assign err_eol_early   = err_eol_early_r;
  assign err_eol_missing = err_eol_missing_r;

endmodule
